reg_file_bus_driver: RTL and testbench

- Register-file side of the one-hot control interface produced by the control-line generator.
- Consumes the per-register load, output-enable and bus-select lines. Holds NREG general registers and writes them from the write-back data.
- Drives the two ALU operand buses, A and B, registered.
- Detects and flags illegal multi-driver selections on either bus.

---
 rtl/reg_file_bus_driver.sv | 116 +++++++++++
 tb/tb_reg_file_bus_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_bus_driver.sv
// reg_file_bus_driver
//   Register-file side of the one-hot control interface. Holds NREG general
//   registers written from the write-back path and drives the two ALU
//   operand buses (A/B) through a registered output stage. Multiple drivers
//   on one bus are OR-combined and flagged.
//
// Ports:
//   clk, rst_n      rising-edge clock, async active-low reset
//   load_reg        per-register write enables (more than one bit allowed)
//   reg_to_bus      per-register bus enables
//   bus_select      per-register bus choice (0 = A, 1 = B)
//   wr_data         write-back data
//   err_clr         synchronous clear of err_sticky
//   bus_a, bus_b    registered operand buses
//   bus_a_vld/_b    registered: bus had at least one driver last cycle
//   conflict        registered pulse: a bus had more than one driver
//   err_sticky      latched conflict, cleared by err_clr

// One register slot: storage plus its masked contribution to each bus.
module reg_file_slot #(
  parameter int DW     = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          rd_en,
  input  logic          sel_b,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] src_a,
  output logic [DW-1:0] src_b
);
  logic [DW-1:0] q;
  logic [DW-1:0] src;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   q <= '0;
    else if (load) q <= wr_data;

  // Same-cycle write forwards wr_data to the bus when bypass is enabled.
  assign src   = (BYPASS && load) ? wr_data : q;
  assign src_a = (rd_en && !sel_b) ? src : '0;
  assign src_b = (rd_en &&  sel_b) ? src : '0;
endmodule

module reg_file_bus_driver #(
  parameter int NREG   = 32,
  parameter int DW     = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREG-1:0] load_reg,
  input  logic [NREG-1:0] reg_to_bus,
  input  logic [NREG-1:0] bus_select,
  input  logic [DW-1:0]   wr_data,
  input  logic            err_clr,
  output logic [DW-1:0]   bus_a,
  output logic [DW-1:0]   bus_b,
  output logic            bus_a_vld,
  output logic            bus_b_vld,
  output logic            conflict,
  output logic            err_sticky
);
  logic [NREG-1:0][DW-1:0] src_a, src_b;
  logic [NREG-1:0]         sel_a, sel_b;
  logic [DW-1:0]           a_nxt, b_nxt;
  logic                    conflict_nxt;

  for (genvar i = 0; i < NREG; i++) begin : g_slot
    reg_file_slot #(.DW(DW), .BYPASS(BYPASS)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_reg[i]),
      .rd_en   (reg_to_bus[i]),
      .sel_b   (bus_select[i]),
      .wr_data (wr_data),
      .src_a   (src_a[i]),
      .src_b   (src_b[i])
    );
  end

  assign sel_a = reg_to_bus & ~bus_select;
  assign sel_b = reg_to_bus &  bus_select;

  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      a_nxt = a_nxt | src_a[i];
      b_nxt = b_nxt | src_b[i];
    end
  end

  // x & (x-1) clears the lowest set bit; non-zero means two or more drivers.
  assign conflict_nxt = (|(sel_a & (sel_a - 1'b1))) | (|(sel_b & (sel_b - 1'b1)));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus_a      <= '0;
      bus_b      <= '0;
      bus_a_vld  <= 1'b0;
      bus_b_vld  <= 1'b0;
      conflict   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      bus_a      <= a_nxt;
      bus_b      <= b_nxt;
      bus_a_vld  <= |sel_a;
      bus_b_vld  <= |sel_b;
      conflict   <= conflict_nxt;
      // A fresh conflict outranks a simultaneous clear.
      if (conflict_nxt)  err_sticky <= 1'b1;
      else if (err_clr)  err_sticky <= 1'b0;
    end
endmodule

// File: tb/tb_reg_file_bus_driver.sv
module tb_reg_file_bus_driver;
  localparam int NREG   = 32;
  localparam int DW     = 16;
  localparam bit BYPASS = 1'b1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREG-1:0] load_reg, reg_to_bus, bus_select;
  logic [DW-1:0]   wr_data;
  logic            err_clr;
  logic [DW-1:0]   bus_a, bus_b;
  logic            bus_a_vld, bus_b_vld, conflict, err_sticky;

  reg_file_bus_driver #(.NREG(NREG), .DW(DW), .BYPASS(BYPASS)) dut (
    .clk(clk), .rst_n(rst_n), .load_reg(load_reg), .reg_to_bus(reg_to_bus),
    .bus_select(bus_select), .wr_data(wr_data), .err_clr(err_clr),
    .bus_a(bus_a), .bus_b(bus_b), .bus_a_vld(bus_a_vld), .bus_b_vld(bus_b_vld),
    .conflict(conflict), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Reference model state.
  logic [DW-1:0] mregs [NREG];
  logic [DW-1:0] ea, eb;
  logic          eav, ebv, ec, ee;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bus_a"},      64'(bus_a),      64'(ea));
    chk({tag, ".bus_b"},      64'(bus_b),      64'(eb));
    chk({tag, ".bus_a_vld"},  64'(bus_a_vld),  64'(eav));
    chk({tag, ".bus_b_vld"},  64'(bus_b_vld),  64'(ebv));
    chk({tag, ".conflict"},   64'(conflict),   64'(ec));
    chk({tag, ".err_sticky"}, 64'(err_sticky), 64'(ee));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    ea = '0; eb = '0; eav = 0; ebv = 0; ec = 0; ee = 0;
  endtask

  // Called at a negedge: apply one control vector, predict the post-edge
  // outputs, then step to the next negedge and compare.
  task automatic cyc(input logic [NREG-1:0] ld, input logic [NREG-1:0] rtb,
                     input logic [NREG-1:0] bs, input logic [DW-1:0] wd,
                     input logic clr, input string tag);
    int na, nb;
    logic [DW-1:0] v;
    load_reg = ld; reg_to_bus = rtb; bus_select = bs; wr_data = wd; err_clr = clr;
    ea = '0; eb = '0; na = 0; nb = 0;
    for (int i = 0; i < NREG; i++) begin
      if (rtb[i]) begin
        v = (BYPASS && ld[i]) ? wd : mregs[i];
        if (bs[i]) begin eb = eb | v; nb++; end
        else       begin ea = ea | v; na++; end
      end
    end
    eav = (na > 0);
    ebv = (nb > 0);
    ec  = (na > 1) || (nb > 1);
    if (ec)       ee = 1'b1;
    else if (clr) ee = 1'b0;
    for (int i = 0; i < NREG; i++) if (ld[i]) mregs[i] = wd;
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [NREG-1:0] r_ld, r_rtb, r_bs;
    rst_n = 1'b0;
    load_reg = '0; reg_to_bus = '0; bus_select = '0; wr_data = '0; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    cyc('0, '0, '0, '0, 1'b0, "idle");

    // Single write then read on A.
    cyc(32'h1 << 5, '0, '0, 16'hA5A5, 1'b0, "wr5");
    cyc('0, 32'h1 << 5, '0, '0, 1'b0, "rd5");
    chk("rd5.const_a", 64'(bus_a), 64'h A5A5);
    chk("rd5.const_bv", 64'(bus_b_vld), 64'h0);

    // Split buses without conflict.
    cyc(32'h1 << 3, '0, '0, 16'h1234, 1'b0, "wr3");
    cyc(32'h1 << 7, '0, '0, 16'h00FF, 1'b0, "wr7");
    cyc('0, 32'h88, 32'h8, '0, 1'b0, "rd37");
    chk("rd37.const_b", 64'(bus_b), 64'h1234);
    chk("rd37.const_a", 64'(bus_a), 64'h00FF);
    chk("rd37.const_c", 64'(conflict), 64'h0);

    // Conflict on A, sticky behaviour.
    cyc(32'h2, '0, '0, 16'h0F00, 1'b0, "wr1");
    cyc(32'h4, '0, '0, 16'h00F0, 1'b0, "wr2");
    cyc('0, 32'h6, '0, '0, 1'b0, "conf");
    chk("conf.const_a", 64'(bus_a), 64'h0FF0);
    chk("conf.const_c", 64'(conflict), 64'h1);
    cyc('0, '0, '0, '0, 1'b0, "conf_hold");
    chk("conf_hold.const_e", 64'(err_sticky), 64'h1);
    cyc('0, 32'h6, '0, '0, 1'b1, "conf_clr");
    chk("conf_clr.const_e", 64'(err_sticky), 64'h1);
    cyc('0, '0, '0, '0, 1'b1, "clr");
    chk("clr.const_e", 64'(err_sticky), 64'h0);

    // Same-cycle read/write of R9.
    cyc(32'h1 << 9, '0, '0, 16'h1111, 1'b0, "wr9");
    cyc(32'h1 << 9, 32'h1 << 9, 32'h1 << 9, 16'h2222, 1'b0, "byp9");
    chk("byp9.const_b", 64'(bus_b), BYPASS ? 64'h2222 : 64'h1111);
    cyc('0, 32'h1 << 9, '0, '0, 1'b0, "rd9");
    chk("rd9.const_a", 64'(bus_a), 64'h2222);

    // Two-hot write, read back on both buses.
    cyc(32'h8000_0001, '0, '0, 16'hBEEF, 1'b0, "wr0_31");
    cyc('0, 32'h8000_0001, 32'h8000_0000, '0, 1'b0, "rd0_31");
    chk("rd0_31.const_a", 64'(bus_a), 64'hBEEF);
    chk("rd0_31.const_b", 64'(bus_b), 64'hBEEF);

    // Randomized traffic with sparse control vectors.
    for (int n = 0; n < 400; n++) begin
      r_ld  = $urandom & $urandom & $urandom;
      r_rtb = $urandom & $urandom & $urandom & $urandom;
      r_bs  = $urandom;
      if ($urandom_range(0, 3) == 0) r_ld = '0;
      cyc(r_ld, r_rtb, r_bs, DW'($urandom), ($urandom_range(0, 3) == 0), "rnd");
    end

    // Asynchronous reset in the middle of a transfer.
    cyc(32'hFFFF_FFFF, '0, '0, 16'h7E7E, 1'b0, "fill");
    load_reg = 32'h1; reg_to_bus = 32'h3; bus_select = '0; wr_data = 16'hCAFE;
    #1;
    cyc('0, 32'h3, '0, '0, 1'b0, "pre_rst");
    load_reg = 32'h10; reg_to_bus = 32'hF; wr_data = 16'h5555;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc('0, 32'h3, 32'h2, '0, 1'b0, "post_rst");
    cyc('0, 32'h10, '0, '0, 1'b0, "post_rst4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
